// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter:
// data width, op code values and the arbiter state encoding.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int OP_W  = 3;

    localparam logic [OP_W-1:0] ADD     = 3'd0;
    localparam logic [OP_W-1:0] SUB     = 3'd1;
    localparam logic [OP_W-1:0] AND     = 3'd2;
    localparam logic [OP_W-1:0] OR      = 3'd3;
    localparam logic [OP_W-1:0] SRL     = 3'd4;
    localparam logic [OP_W-1:0] SRA     = 3'd5;
    localparam logic [OP_W-1:0] OP_LAST = SRA;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: add, sub, and, or, logical and arithmetic
// right shift. Op codes above OP_LAST produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] c
);

    always_comb begin
        c = '0;
        case (op)
            ADD:     c = a + b;
            SUB:     c = a - b;
            AND:     c = a & b;
            OR:      c = a | b;
            SRL:     c = a >> b[4:0];
            SRA:     c = WIDTH'($signed(a) >>> b[4:0]);
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready request ports.
// One operation in flight; result is held until its owner accepts it.
module alu_arbiter #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OP_W  = alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_err
);
    import alu_pkg::state_e;
    import alu_pkg::IDLE;
    import alu_pkg::EXEC;
    import alu_pkg::RESP;
    import alu_pkg::OP_LAST;

    state_e           state_reg, state_next;
    logic             prio_reg;
    logic             owner_reg;
    logic             err_reg;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [OP_W-1:0]  op_reg;

    logic             grant;
    logic             take;
    logic             accept;
    logic             illegal;
    logic [WIDTH-1:0] alu_c;

    // A lone requester always wins; prio only breaks ties.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = prio_reg;
        end
    end

    assign req0_ready = !reset && (state_reg == IDLE) && req0_valid && !grant;
    assign req1_ready = !reset && (state_reg == IDLE) && req1_valid && grant;
    assign take       = req0_ready || req1_ready;
    assign accept     = (state_reg == RESP) && (owner_reg ? rsp1_ready : rsp0_ready);
    assign illegal    = op_reg > OP_W'(OP_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_reg  <= 1'b0;
            owner_reg <= 1'b0;
            err_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            res_reg   <= '0;
        end else begin
            if (take) begin
                owner_reg <= grant;
                a_reg     <= grant ? req1_a  : req0_a;
                b_reg     <= grant ? req1_b  : req0_b;
                op_reg    <= grant ? req1_op : req0_op;
            end
            if (state_reg == EXEC) begin
                res_reg <= illegal ? '0 : alu_c;
                err_reg <= illegal;
            end
            if (accept) begin
                prio_reg <= ~owner_reg;
            end
        end
    end

    alu u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .c  (alu_c)
    );

    // Non-owner response outputs read as zero.
    assign rsp0_valid = (state_reg == RESP) && !owner_reg;
    assign rsp1_valid = (state_reg == RESP) && owner_reg;
    assign rsp0_c     = rsp0_valid ? res_reg : '0;
    assign rsp1_c     = rsp1_valid ? res_reg : '0;
    assign rsp0_err   = rsp0_valid && err_reg;
    assign rsp1_err   = rsp1_valid && err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized transactions on both ports of alu_arbiter, checked
// against an arithmetic result model and a round-robin priority model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] a_in [2];
    logic [31:0] b_in [2];
    logic [2:0]  op_in [2];

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_c, rsp1_c;

    int n_cmp = 0;
    int n_bad = 0;
    int prio_m = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req_valid[0]),
        .req0_ready (req0_ready),
        .req0_a     (a_in[0]),
        .req0_b     (b_in[0]),
        .req0_op    (op_in[0]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp_ready[0]),
        .rsp0_c     (rsp0_c),
        .rsp0_err   (rsp0_err),
        .req1_valid (req_valid[1]),
        .req1_ready (req1_ready),
        .req1_a     (a_in[1]),
        .req1_b     (b_in[1]),
        .req1_op    (op_in[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp_ready[1]),
        .rsp1_c     (rsp1_c),
        .rsp1_err   (rsp1_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_c(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        int sh;
        sh = int'(b % 32);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a >> sh;
            3'd5:    return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic get_ready(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic get_rvalid(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [31:0] get_c(input int p);
        return (p == 0) ? rsp0_c : rsp1_c;
    endfunction

    function automatic logic get_err(input int p);
        return (p == 0) ? rsp0_err : rsp1_err;
    endfunction

    // Called and returns just after a rising edge.
    task automatic transact(input logic [1:0] vmask, input bit keep, input int bp);
        int          g, exp_g, waited;
        logic [31:0] exp_c, opa, opb;
        logic [2:0]  opc;
        logic        exp_err;
        req_valid = vmask;
        waited = 0;
        @(negedge clk);
        while (!(req0_ready || req1_ready) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) begin
            check_val("grant_timeout", 32'(waited), 32'd0);
            req_valid = 2'b00;
            @(posedge clk);
            #1;
            return;
        end
        exp_g = (vmask == 2'b11) ? prio_m : (vmask[1] ? 1 : 0);
        g = req1_ready ? 1 : 0;
        check_val("grant_port", 32'(g), 32'(exp_g));
        check_val("ready_other", 32'(get_ready(1 - g)), 32'd0);
        last_wait = waited;
        opa = a_in[g];
        opb = b_in[g];
        opc = op_in[g];
        exp_c = ref_c(opa, opb, opc);
        exp_err = (opc > 3'd5);
        @(posedge clk);
        #1;
        if (!keep) req_valid[g] = 1'b0;
        rsp_ready = 2'b00;
        rsp_ready[1 - g] = 1'b1;
        @(negedge clk);
        check_val("exec_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check_val("exec_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        check_val("rsp_valid_owner", 32'(get_rvalid(g)), 32'd1);
        check_val("rsp_valid_other", 32'(get_rvalid(1 - g)), 32'd0);
        check_val("rsp_c", get_c(g), exp_c);
        check_val("rsp_err", 32'(get_err(g)), 32'(exp_err));
        check_val("rsp_other_zero", get_c(1 - g) | 32'(get_err(1 - g)), 32'd0);
        check_val("resp_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_val("bp_c_stable", get_c(g), exp_c);
            check_val("bp_valid", 32'(get_rvalid(g)), 32'd1);
            check_val("bp_req_ready", 32'({req1_ready, req0_ready}), 32'd0);
        end
        rsp_ready = 2'b00;
        rsp_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        check_val("done_rsp_valid", 32'(get_rvalid(g)), 32'd0);
        prio_m = 1 - g;
        $display("txn port=%0d op=%0d a=%08h b=%08h c=%08h err=%0d wait=%0d bp=%0d",
                 g, opc, opa, opb, exp_c, exp_err, waited, bp);
    endtask

    task automatic reset_mid(input bit in_resp);
        a_in[0] = 32'd7; b_in[0] = 32'd9; op_in[0] = 3'd0;
        transact(2'b01, 1'b0, 0);
        a_in[1] = 32'h1234; b_in[1] = 32'h1; op_in[1] = 3'd0;
        req_valid = 2'b10;
        @(negedge clk);
        check_val("rst_start_grant", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        @(negedge clk);
        if (in_resp) begin
            @(negedge clk);
            check_val("rst_pre_rsp_valid", 32'(rsp1_valid), 32'd1);
        end
        reset = 1'b1;
        #1;
        check_val("rst_flags", 32'({req1_ready, req0_ready, rsp1_valid, rsp0_valid,
                                    rsp1_err, rsp0_err}), 32'd0);
        check_val("rst_rsp_c", rsp0_c | rsp1_c, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_no_response", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        end
        rsp_ready = 2'b00;
        prio_m = 0;
        @(posedge clk);
        #1;
        a_in[0] = 32'd2; b_in[0] = 32'd3; op_in[0] = 3'd2;
        a_in[1] = 32'd4; b_in[1] = 32'd1; op_in[1] = 3'd1;
        transact(2'b11, 1'b0, 0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            a_in[p] = 32'd0; b_in[p] = 32'd0; op_in[p] = 3'd0;
        end
        req_valid = 2'b11;
        @(negedge clk);
        check_val("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check_val("reset_rsp", 32'({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}), 32'd0);
        check_val("reset_rsp_c", rsp0_c | rsp1_c, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 2'b00;

        // first grant after reset goes to port 0
        a_in[0] = 32'd1; b_in[0] = 32'd1; op_in[0] = 3'd0;
        a_in[1] = 32'hF0; b_in[1] = 32'h0F; op_in[1] = 3'd3;
        transact(2'b11, 1'b0, 0);

        // lone port 0 wins regardless of priority; back-to-back in 3 cycles
        a_in[0] = 32'd5; b_in[0] = 32'd3; op_in[0] = 3'd0;
        transact(2'b01, 1'b1, 0);
        a_in[0] = 32'd3; b_in[0] = 32'd5; op_in[0] = 3'd1;
        transact(2'b01, 1'b0, 0);
        check_val("back_to_back_wait", 32'(last_wait), 32'd0);

        a_in[1] = 32'hF000_0000; b_in[1] = 32'd2; op_in[1] = 3'd5;
        transact(2'b10, 1'b0, 0);
        op_in[1] = 3'd4;
        transact(2'b10, 1'b0, 0);

        // both ports continuously valid: grants alternate
        a_in[0] = 32'd1; b_in[0] = 32'd1; op_in[0] = 3'd0;
        a_in[1] = 32'hF0; b_in[1] = 32'h0F; op_in[1] = 3'd3;
        for (int r = 0; r < 4; r++) begin
            transact(2'b11, 1'b1, 0);
            if (r > 0) check_val("alternate_wait", 32'(last_wait), 32'd0);
        end

        // backpressure on port 0 while port 1 waits
        a_in[0] = 32'hDEAD_BEEF; b_in[0] = 32'h1111_1111; op_in[0] = 3'd1;
        transact(2'b11, 1'b0, 10);
        transact(2'b10, 1'b0, 0);
        check_val("bp_next_grant_wait", 32'(last_wait), 32'd0);

        // illegal op followed by a legal one
        a_in[0] = 32'd1; b_in[0] = 32'd1; op_in[0] = 3'd7;
        transact(2'b01, 1'b0, 0);
        op_in[0] = 3'd6;
        transact(2'b01, 1'b0, 1);
        op_in[0] = 3'd2;
        transact(2'b01, 1'b0, 0);

        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 2; p++) begin
                a_in[p] = $urandom;
                b_in[p] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                op_in[p] = 3'($urandom_range(0, 7));
            end
            transact(2'($urandom_range(1, 3)), 1'b0, $urandom_range(0, 3));
        end

        reset_mid(1'b0);
        reset_mid(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, such as a scalar issue path and a debug/self-test port. Each port uses a valid/ready handshake. Grants alternate round-robin between the ports. Operands and op are registered before they reach the ALU, and each result is held in a per-transaction response register until the owning port accepts it. Only one operation is in flight at any time.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Must match `alu`, which is 32.
- `OP_W`, default 3: width of the ALU op code.

Ports (`n` ∈ {0,1}, each signal duplicated per port):
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqn_valid`  in  1  request pending on port n.
- `reqn_ready`  out  1  port n granted; handshake occurs when valid and ready are both high at an edge.
- `reqn_a`  in  WIDTH  operand A.
- `reqn_b`  in  WIDTH  operand B.
- `reqn_op`  in  OP_W  op code: 0 add, 1 sub, 2 and, 3 or, 4 srl (A>>B[4:0]), 5 sra (A>>>B[4:0]), 6 and 7 illegal.
- `rspn_valid`  out  1  result available for port n.
- `rspn_ready`  in  1  port n accepts the result.
- `rspn_c`  out  WIDTH  result.
- `rspn_err`  out  1  the op was illegal; `rspn_c` = 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant goes to the single valid port. If both ports are valid, it goes to the port selected by the priority pointer `prio` (reset value 0).
  - Only the granted port sees `reqn_ready`=1, combinationally from valid and `prio`. The other port's ready is 0.
  - On handshake: latch a, b, op and `owner` into registers, then go to EXEC.
- EXEC:
  - `alu` is driven from the latched registers.
  - At the edge, capture `C` into `res`, set `err` = (op > 5) and force `res` = 0 if illegal, then go to RESP.
- RESP:
  - Assert `rsp[owner]_valid`. `rspn_c` and `rspn_err` reflect `res`/`err` only for the owner; other ports read 0.
  - On `rsp[owner]_ready` at an edge: go to IDLE and set `prio` = ~`owner`.
- Shift amounts use `B[4:0]`. Add and sub wrap modulo 2^32, with no carry or overflow output.
- Both `reqn_ready` signals are 0 outside IDLE. A port's valid may drop before it is granted; nothing is latched in that case.

## Timing
- Reset (async, immediate): state = IDLE, `prio` = 0, `res` = 0, `err` = 0, `owner` = 0. All `reqn_ready`, `rspn_valid`, `rspn_c` and `rspn_err` are 0 while reset is asserted.
- Latency: handshake at edge N means EXEC during cycle N..N+1, and `rspn_valid` is high from edge N+1.
- Minimum 3 cycles per operation when `rsp_ready` is held high.
- Backpressure: RESP holds indefinitely and `res` is stable. The other port's request waits with ready = 0.
- Simultaneous requests in IDLE: `prio` decides. After completion the other port has priority, so no starvation occurs. A lone requester is granted every time regardless of `prio`.
- Reset during EXEC or RESP discards the operation with no response. After reset deasserts, port 0 has priority.
- `rspn_ready` asserted while `rspn_valid` is low is ignored.

## Structure
- Shared package `alu_pkg`:
  - op code constants ADD=0, SUB=1, AND=2, OR=3, SRL=4, SRA=5, and `OP_LAST`=5;
  - FSM state encoding;
  - `WIDTH`.
- Sub-module: exactly one instance of the existing `alu`. The arbiter owns all registers and contains no arithmetic of its own.
- The grant logic is small and stays inline; it needs no separate module.

## Test plan
- Port 0 only: A=5, B=3, op 0, `rsp0_ready`=1. Expect `rsp0_c`=8 with `rsp0_valid` at edge N+1, and `req0_ready` again 2 cycles later.
- Port 1, sra: A=0xF000_0000, B=2, op 5. Expect 0xFC00_0000. The same operands with op 4 give 0x3C00_0000. Sub 3−5 gives 0xFFFF_FFFE.
- Both ports valid continuously, with port 0 doing add 1+1 and port 1 doing or 0xF0|0x0F:
  - grants alternate 0,1,0,1;
  - port 0 gets 2 and port 1 gets 0xFF;
  - the first grant after reset goes to port 0.
- Backpressure: hold `rsp0_ready`=0 for 10 cycles while port 1 is valid. Expect `rsp0_c` stable, `req1_ready` held at 0, and port 1 granted the cycle after `rsp0_ready` rises.
- Illegal op 7 with A=1, B=1. Expect `rsp_err`=1, `rsp_c`=0, and normal completion. The next legal op gives `err`=0.
- Assert `reset` during EXEC, then again during RESP. Expect all outputs to drop to 0 immediately, no response to be delivered, and `prio`=0 after release.
